// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : hilo_muldiv_ctrl_pkg                                               |
// | Purpose : Operation codes, FSM state encodings and default sizes shared by   |
// |           the HI/LO multiply/divide sequencer, its bus interface and its     |
// |           iterative datapath.                                                |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package hilo_muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  // op_i encodings, kept alongside the ALU control codes
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : hilo_muldiv_ctrl_if                                              |
// | Purpose   : Execute-stage <-> HI/LO sequencer signal bundle.                 |
// | Signals   : start_i, op_i[2:0], src0_i, src1_i, flush_i  (execute -> seq)    |
// |             hi_o, lo_o, busy_o, done_o                    (seq -> execute)   |
// | Modports  : master = execute stage, slave = sequencer                        |
// | Rev       : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface hilo_muldiv_ctrl_if
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src0_i;
  logic [WIDTH-1:0] src1_i;
  logic             flush_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, op_i, src0_i, src1_i, flush_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, src0_i, src1_i, flush_i,
    output hi_o, lo_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_iter_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_iter_dp                                                     |
// | Purpose : Radix-2 iterative datapath: shift-add multiply or restoring        |
// |           divide, one bit per enabled cycle, on unsigned magnitudes.         |
// | Ports   : clk, rst_n (async, active low)                                     |
// |           i_load      - load i_acc_init into acc low half, i_opnd_init       |
// |           i_step      - perform one iteration                                |
// |           i_is_div    - 1 = divide step, 0 = multiply step                   |
// |           i_acc_init  - multiplier (mul) or dividend (div)                   |
// |           i_opnd_init - multiplicand (mul) or divisor (div)                  |
// |           o_acc       - mul: {hi,lo} product; div: {remainder, quotient}     |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module muldiv_iter_dp
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_load,
  input  wire logic                 i_step,
  input  wire logic                 i_is_div,
  input  wire logic [WIDTH-1:0]     i_acc_init,
  input  wire logic [WIDTH-1:0]     i_opnd_init,
  output      logic [2*WIDTH-1:0]   o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: conditional add into the upper half, carry kept, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: the shifted remainder needs one extra bit before the trial
  // subtract; after a successful subtract the result is below the divisor,
  // so the low WIDTH bits of the difference are exact.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_fits     = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_fits ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= {{WIDTH{1'b0}}, i_acc_init};
      r_opnd <= i_opnd_init;
    end else if (i_step) begin
      r_acc  <= i_is_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hilo_muldiv_ctrl                                                   |
// | Purpose : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also       |
// |           services MTHI/MTLO writes. Sequence IDLE->PREP->CALC(xWIDTH)->FIX. |
// | Ports   : clk_i   - clock, rising edge                                       |
// |           rst_n_i - asynchronous active-low reset                            |
// |           bus     - hilo_muldiv_ctrl_if.slave (start/op/src0/src1/flush in,  |
// |                     hi/lo/busy/done out)                                     |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  wire logic          clk_i,
  input  wire logic          rst_n_i,
  hilo_muldiv_ctrl_if.slave  bus
);

  logic [1:0]         r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_is_signed;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_sign_q, r_sign_r, r_div0;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_req, w_accept, w_mthi, w_mtlo;
  logic               w_load, w_step, w_fix;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH-1:0]   w_acc_init, w_opnd_init;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  // A flush in IDLE drops any request, MT writes included.
  assign w_req    = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign w_accept = w_req && ((bus.op_i == MD_OP_MULT) || (bus.op_i == MD_OP_MULTU) ||
                              (bus.op_i == MD_OP_DIV)  || (bus.op_i == MD_OP_DIVU));
  assign w_mthi   = w_req && (bus.op_i == MD_OP_MTHI);
  assign w_mtlo   = w_req && (bus.op_i == MD_OP_MTLO);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_PREP;
      ST_PREP: w_next_state = bus.flush_i ? ST_IDLE : ST_CALC;
      ST_CALC: begin
        if (bus.flush_i)                      w_next_state = ST_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))  w_next_state = ST_FIX;
      end
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_load = (r_state == ST_PREP);
    w_step = (r_state == ST_CALC);
    // flush beats completion in the FIX cycle
    w_fix  = (r_state == ST_FIX) && !bus.flush_i;
  end

  // Operand capture, sign bookkeeping and iteration counter
  assign w_mag_a = (r_is_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b = (r_is_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div0      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_is_div    <= (bus.op_i == MD_OP_DIV) || (bus.op_i == MD_OP_DIVU);
        r_is_signed <= (bus.op_i == MD_OP_MULT) || (bus.op_i == MD_OP_DIV);
        r_a         <= bus.src0_i;
        r_b         <= bus.src1_i;
      end
      if (w_load) begin
        r_sign_q <= r_is_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_sign_r <= r_is_signed && r_a[WIDTH-1];
        r_div0   <= (r_b == '0);
        r_cnt    <= '0;
      end else if (w_step) begin
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Multiply iterates over the multiplier held in the accumulator low half;
  // divide shifts the dividend out of it.
  assign w_acc_init  = r_is_div ? w_mag_a : w_mag_b;
  assign w_opnd_init = r_is_div ? w_mag_b : w_mag_a;

  muldiv_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_is_div    (r_is_div),
    .i_acc_init  (w_acc_init),
    .i_opnd_init (w_opnd_init),
    .o_acc       (w_acc)
  );

  // Result fixup
  assign w_prod = r_sign_q ? -w_acc : w_acc;
  assign w_quo  = w_acc[WIDTH-1:0];
  assign w_rem  = w_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_sign_r ? -w_rem : w_rem;
        w_res_lo = r_sign_q ? -w_quo : w_quo;
      end
    end
  end

  // HI/LO registers and done pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_mthi) r_hi <= bus.src0_i;
        if (w_mtlo) r_lo <= bus.src0_i;
      end
    end
  end

  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;
  assign bus.busy_o = (r_state != ST_IDLE);
  assign bus.done_o = r_done;

endmodule
`default_nettype wire
